// File: rtl/formula_sum_isqrt_fsm_if.sv
// Bus bundle for formula_sum_isqrt_fsm: argument request/result handshake
// on one side and the per-unit isqrt operand/root channels on the other.
// The slave modport is the FSM's view; master is the surrounding system
// (argument producer plus the bank of isqrt units).
interface formula_sum_isqrt_fsm_if #(
    parameter int N_ARGS  = 3,
    parameter int N_UNITS = 2,
    parameter int RES_W   = 32
);
    logic                    arg_vld;
    logic [N_ARGS*32-1:0]    args;
    logic                    arg_rdy;
    logic                    res_vld;
    logic [RES_W-1:0]        res;
    logic [N_UNITS-1:0]      isqrt_x_vld;
    logic [N_UNITS*32-1:0]   isqrt_x;
    logic [N_UNITS-1:0]      isqrt_y_vld;
    logic [N_UNITS*16-1:0]   isqrt_y;

    modport slave (
        input  arg_vld, args, isqrt_y_vld, isqrt_y,
        output arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
    );

    modport master (
        output arg_vld, args, isqrt_y_vld, isqrt_y,
        input  arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
    );
endinterface

// File: rtl/formula_sum_isqrt_fsm.sv
// formula_sum_isqrt_fsm: res = sum over i of isqrt(arg[i]), computed by
// dispatching the arguments in batches of up to N_UNITS to external isqrt
// units and accumulating their roots as they come back (in any order).
// The next batch is issued in the same cycle the current one completes, so
// there are no bubbles between batches.
// Optional build macro: FORMULA_SUM_ISQRT_ERR_EN adds a sticky 'err' output
// that flags a root strobe arriving on a unit with nothing outstanding.
module formula_sum_isqrt_fsm #(
    parameter int N_ARGS  = 3,
    parameter int N_UNITS = 2,
    parameter int RES_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    formula_sum_isqrt_fsm_if.slave bus
`ifdef FORMULA_SUM_ISQRT_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int N_BATCH = (N_ARGS + N_UNITS - 1) / N_UNITS;
    localparam int BATCH_W = (N_BATCH > 1) ? $clog2(N_BATCH) : 1;
    localparam logic [BATCH_W-1:0] LAST_BATCH = BATCH_W'(N_BATCH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [BATCH_W-1:0]     batch_r;
    logic [BATCH_W-1:0]     issue_batch_s;
    logic [N_UNITS-1:0]     pend_r;
    logic [N_UNITS-1:0]     resp_s;
    logic [N_UNITS-1:0]     x_vld_s;
    logic [N_UNITS*32-1:0]  x_s;
    logic [N_ARGS*32-1:0]   args_r;
    logic [N_ARGS*32-1:0]   src_args_s;
    logic [RES_W-1:0]       res_r;
    logic                   res_vld_r;
    logic                   accept_s;
    logic                   batch_done_s;
    logic                   advance_s;
    logic                   finish_s;
    logic                   issue_s;

    // Units that carry an argument in batch k (the tail batch may be partial).
    function automatic logic [N_UNITS-1:0] batch_mask(input logic [BATCH_W-1:0] k);
        logic [N_UNITS-1:0] m;
        m = {N_UNITS{1'b0}};
        for (int u = 0; u < N_UNITS; u++) begin
            if ((int'(k) * N_UNITS + u) < N_ARGS) begin
                m[u] = 1'b1;
            end else begin
                m[u] = 1'b0;
            end
        end
        return m;
    endfunction

    // Operands for batch k: argument i goes to unit i % N_UNITS in batch i / N_UNITS.
    function automatic logic [N_UNITS*32-1:0] batch_operands(
        input logic [BATCH_W-1:0]   k,
        input logic [N_ARGS*32-1:0] a
    );
        logic [N_UNITS*32-1:0] x;
        x = {(N_UNITS*32){1'b0}};
        for (int i = 0; i < N_ARGS; i++) begin
            if (k == BATCH_W'(i / N_UNITS)) begin
                x[32*(i % N_UNITS) +: 32] = a[32*i +: 32];
            end else begin
                x = x;
            end
        end
        return x;
    endfunction

    // Sum of zero-extended roots for the units selected by m.
    function automatic logic [RES_W-1:0] root_sum(
        input logic [N_UNITS-1:0]    m,
        input logic [N_UNITS*16-1:0] y
    );
        logic [RES_W-1:0] s;
        s = {RES_W{1'b0}};
        for (int u = 0; u < N_UNITS; u++) begin
            if (m[u]) begin
                s = s + RES_W'(y[16*u +: 16]);
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

    // Handshake decode: acceptance, batch completion and which batch to issue.
    always_comb begin
        accept_s     = (state_r == ST_IDLE) && bus.arg_vld;
        resp_s       = bus.isqrt_y_vld & pend_r;
        batch_done_s = (state_r == ST_WAIT) &&
                       ((pend_r & ~bus.isqrt_y_vld) == {N_UNITS{1'b0}});
        advance_s    = batch_done_s && (batch_r != LAST_BATCH);
        finish_s     = batch_done_s && (batch_r == LAST_BATCH);
        issue_s      = accept_s || advance_s;
        if (state_r == ST_IDLE) begin
            issue_batch_s = {BATCH_W{1'b0}};
            src_args_s    = bus.args;
        end else begin
            issue_batch_s = batch_r + BATCH_W'(1);
            src_args_s    = args_r;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: leave IDLE on acceptance, return once the last batch completes.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (finish_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: ready in IDLE, start strobes/operands for the batch being issued.
    always_comb begin
        bus.arg_rdy = 1'b0;
        x_vld_s     = {N_UNITS{1'b0}};
        x_s         = batch_operands(issue_batch_s, src_args_s);
        case (state_r)
            ST_IDLE: begin
                bus.arg_rdy = 1'b1;
                if (issue_s) begin
                    x_vld_s = batch_mask(issue_batch_s);
                end else begin
                    x_vld_s = {N_UNITS{1'b0}};
                end
            end
            ST_WAIT: begin
                bus.arg_rdy = 1'b0;
                if (issue_s) begin
                    x_vld_s = batch_mask(issue_batch_s);
                end else begin
                    x_vld_s = {N_UNITS{1'b0}};
                end
            end
            default: begin
                bus.arg_rdy = 1'b0;
                x_vld_s     = {N_UNITS{1'b0}};
            end
        endcase
    end

    assign bus.isqrt_x_vld = x_vld_s;
    assign bus.isqrt_x     = x_s;
    assign bus.res         = res_r;
    assign bus.res_vld     = res_vld_r;

    // Pending flags, batch index and the latched argument vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r  <= {N_UNITS{1'b0}};
            batch_r <= {BATCH_W{1'b0}};
            args_r  <= {(N_ARGS*32){1'b0}};
        end else begin
            pend_r <= (pend_r & ~bus.isqrt_y_vld) | x_vld_s;
            if (accept_s) begin
                args_r  <= bus.args;
                batch_r <= {BATCH_W{1'b0}};
            end else if (advance_s) begin
                batch_r <= batch_r + BATCH_W'(1);
            end else begin
                batch_r <= batch_r;
            end
        end
    end

    // Accumulate roots of pending units; clear on acceptance; pulse done after the last batch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_r     <= {RES_W{1'b0}};
            res_vld_r <= 1'b0;
        end else begin
            res_vld_r <= finish_s;
            if (accept_s) begin
                res_r <= {RES_W{1'b0}};
            end else begin
                res_r <= res_r + root_sum(resp_s, bus.isqrt_y);
            end
        end
    end

`ifdef FORMULA_SUM_ISQRT_ERR_EN
    logic err_r;

    // Sticky flag: a root strobe on a unit with no outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | (|(bus.isqrt_y_vld & ~pend_r));
        end
    end

    assign err = err_r;
`endif

endmodule
